// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and datapath select codes.
// The ALU decoder imports the alu_op encodings from here as well.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // State that follows DECODE for a given opcode.
  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: decode_next = MEMADR;
      OP_RTYPE:          decode_next = EXECUTER;
      OP_ITYPE:          decode_next = EXECUTEI;
      OP_BRANCH:         decode_next = BEQ;
      OP_JAL:            decode_next = JAL;
      default:           decode_next = ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_instr_counter.sv
// Retired-instruction counter: adds one per retire pulse, wraps modulo 2^INSTRET_W.
module multicycle_controller_instr_counter #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 retire,
  output logic [INSTRET_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (retire)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core (fetch/decode/execute/memory/writeback).
// Define ILLEGAL_TRAP_EN to make an illegal opcode a terminal trap; otherwise it retires as a NOP.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_update,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal_instr,
  output logic [3:0]           dbg_state
);

  // mem_ready handshake: the memory access presented in FETCH, MEMREAD or MEMWRITE
  // completes in the cycle mem_ready is 1; the FSM holds its state until then.
  state_t state;
  logic   pc_write;
  logic   branch;
  logic   ir_w;
  logic   mem_w;
  logic   reg_w;
  logic   retire;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      illegal_instr <= 1'b0;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          state <= decode_next(opcode);
`ifdef ILLEGAL_TRAP_EN
          if (decode_next(opcode) == ILLEGAL) illegal_instr <= 1'b1;
`endif
        end
        MEMADR:   state <= opcode[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
`ifdef ILLEGAL_TRAP_EN
        ILLEGAL:  state <= ILLEGAL;
`else
        ILLEGAL:  state <= FETCH;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    case (state)
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_w       = mem_ready;
        pc_write   = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_MEMDATA;
        reg_w      = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      ALUWB:    reg_w = 1'b1;
      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset is synchronous, so the state may still be mid-instruction during a reset cycle.
  assign pc_update = ~reset & (pc_write | (branch & zero));
  assign ir_write  = ~reset & ir_w;
  assign mem_write = ~reset & mem_w;
  assign reg_write = ~reset & reg_w;

  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, ALUWB, BEQ: retire = 1'b1;
      MEMWRITE:          retire = mem_ready;
`ifndef ILLEGAL_TRAP_EN
      ILLEGAL:           retire = 1'b1;
`endif
      default:           retire = 1'b0;
    endcase
    retire = retire & ~reset;
  end

  multicycle_controller_instr_counter #(
    .INSTRET_W (INSTRET_W)
  ) u_instr_counter (
    .clk    (clk),
    .reset  (reset),
    .retire (retire),
    .count  (instret)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction expected control words from the
// instruction-class step table, checked every cycle; follows ILLEGAL_TRAP_EN when defined.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam int IW = 3;
  localparam int W  = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          pc_update, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic [IW-1:0] instret;
  logic [3:0]    dbg_state;

  int tests  = 0;
  int failed = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  cur_exp;
  logic [IW-1:0] exp_instret = '0;
  logic          exp_illegal = 1'b0;

  multicycle_controller #(.INSTRET_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_update     (pc_update),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .instret       (instret),
    .illegal_instr (illegal_instr),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word order: pc_update adr_src mem_write ir_write result_src src_a src_b alu_op reg_write illegal state instret
  function automatic logic [W-1:0] pack(input logic pcu, input logic adr, input logic mw, input logic irw,
                                        input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] op, input logic rw, input state_t st);
    return {pcu, adr, mw, irw, res, sa, sb, op, rw, exp_illegal, 4'(st), exp_instret};
  endfunction

  // Control word each state must show, straight from the state table.
  function automatic logic [W-1:0] expect_word(input state_t st, input logic mr, input logic z);
    case (st)
      FETCH:    return pack(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 0, st);
      DECODE:   return pack(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, st);
      MEMADR:   return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, st);
      MEMREAD:  return pack(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, st);
      MEMWB:    return pack(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, st);
      MEMWRITE: return pack(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, st);
      EXECUTER: return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, st);
      EXECUTEI: return pack(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, st);
      ALUWB:    return pack(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, st);
      BEQ:      return pack(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, st);
      JAL:      return pack(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, st);
      default:  return pack(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, st);
    endcase
  endfunction

  always @(negedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      cur_exp = exp_q.pop_front();
      check($sformatf("ctrl_word state=%0d", cur_exp[IW+3:IW]),
            32'({pc_update, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                 alu_op, reg_write, illegal_instr, dbg_state, instret}),
            32'(cur_exp));
    end
  end

  // One cycle: drive inputs at negedge and queue what the outputs must be.
  task automatic step(input state_t st, input logic mr, input logic z);
    @(negedge clk);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(expect_word(st, mr, z));
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [6:0] op, input int fetch_wait, input int mem_wait, input logic z);
    opcode = op;
    repeat (fetch_wait) step(FETCH, 0, rnd());
    step(FETCH, 1, rnd());
    step(DECODE, rnd(), rnd());
    case (op)
      OP_LOAD: begin
        step(MEMADR, rnd(), rnd());
        repeat (mem_wait) step(MEMREAD, 0, rnd());
        step(MEMREAD, 1, rnd());
        step(MEMWB, rnd(), rnd());
      end
      OP_STORE: begin
        step(MEMADR, rnd(), rnd());
        repeat (mem_wait) step(MEMWRITE, 0, rnd());
        step(MEMWRITE, 1, rnd());
      end
      OP_RTYPE: begin
        step(EXECUTER, rnd(), rnd());
        step(ALUWB, rnd(), rnd());
      end
      OP_ITYPE: begin
        step(EXECUTEI, rnd(), rnd());
        step(ALUWB, rnd(), rnd());
      end
      OP_BRANCH: step(BEQ, rnd(), z);
      OP_JAL: begin
        step(JAL, rnd(), rnd());
        step(ALUWB, rnd(), rnd());
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        exp_illegal = 1'b1;
        repeat (20) step(ILLEGAL, rnd(), rnd());
`else
        step(ILLEGAL, rnd(), rnd());
`endif
      end
    endcase
`ifdef ILLEGAL_TRAP_EN
    if (!exp_illegal) exp_instret = exp_instret + 1'b1;
`else
    exp_instret = exp_instret + 1'b1;
`endif
  endtask

  task automatic check_reset_cycle(input string tag);
    #1;
    check({tag, "_pc_update"}, 32'(pc_update), 0);
    check({tag, "_ir_write"},  32'(ir_write),  0);
    check({tag, "_mem_write"}, 32'(mem_write), 0);
    check({tag, "_reg_write"}, 32'(reg_write), 0);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 7'd0;
    @(posedge clk);
    @(negedge clk);
    check_reset_cycle("reset");
    check("reset_state",   32'(dbg_state),     32'(FETCH));
    check("reset_instret", 32'(instret),       0);
    check("reset_illegal", 32'(illegal_instr), 0);
    reset = 1'b0; mem_ready = 1'b0;

    run_instr(OP_LOAD, 0, 0, 0);
    @(negedge clk); #3;
    check("instret_after_lw", 32'(instret), 1);
    mem_ready = 1'b0;

    run_instr(OP_STORE, 1, 3, 0);
    run_instr(OP_BRANCH, 0, 0, 1);
    run_instr(OP_BRANCH, 0, 0, 0);
    run_instr(OP_RTYPE, 0, 0, 0);
    run_instr(OP_JAL, 0, 0, 0);
    run_instr(OP_ITYPE, 2, 0, 0);
    run_instr(OP_LOAD, 0, 2, 0);
    @(negedge clk); #3;
    check("instret_wrap_after_8", 32'(instret), 0);
    mem_ready = 1'b0;

    run_instr(OP_BRANCH, 0, 0, 1);
    @(negedge clk); #3;
    check("instret_after_9", 32'(instret), 1);

    // Abandon a load in MEMREAD with mem_ready high.
    opcode = OP_LOAD;
    step(FETCH, 1, 0);
    step(DECODE, 0, 0);
    step(MEMADR, 0, 0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1;
    check_reset_cycle("midreset");
    check("midreset_in_memread", 32'(dbg_state), 32'(MEMREAD));
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    check("midreset_state",   32'(dbg_state), 32'(FETCH));
    check("midreset_instret", 32'(instret),   0);
    exp_instret = '0;

    run_instr(7'b1111111, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    #3;
    check("trap_instret_frozen", 32'(instret), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; exp_illegal = 1'b0;
    #1;
    check("trap_cleared", 32'(illegal_instr), 0);
`else
    run_instr(OP_RTYPE, 0, 0, 0);
    @(negedge clk); #3;
    check("nop_illegal_retired", 32'(instret), 2);
`endif

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
